voice_allocator: RTL and testbench

Voice allocator for the 12-voice synthesizer. It takes key-on/key-off events from the keypad decoder and assigns notes to voice slots. It drives the per-voice enable mask consumed by the signal mixer and the per-voice note codes consumed by the oscillators. When all voices are busy, it steals the oldest voice.

---
 rtl/voice_allocator.sv | 187 ++++++++++++++++++
 tb/tb_voice_allocator.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Voice allocator: maps key-on/key-off events onto a fixed pool of voice slots,
// tracks per-voice age ranks and steals the oldest voice when the pool is full.
module voice_allocator #(
    parameter int NUM_VOICES = 12,
    parameter int NOTE_W     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_on,
    input  logic                         key_off,
    input  logic [NOTE_W-1:0]            key_note,
    output logic [NUM_VOICES-1:0]        voice_enable,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_retrig,
    output logic                         steal,
    output logic [3:0]                   active_count
);

    localparam int RANK_W = $clog2(NUM_VOICES);
    localparam logic [RANK_W-1:0] OLDEST_RANK = RANK_W'(NUM_VOICES - 1);
    localparam logic [RANK_W-1:0] RANK_ONE    = RANK_W'(1);

    function automatic logic [3:0] popcount(input logic [NUM_VOICES-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    logic [NUM_VOICES-1:0] active_r;
    logic [NOTE_W-1:0]     note_r [NUM_VOICES];
    logic [RANK_W-1:0]     rank_r [NUM_VOICES];
    logic [NUM_VOICES-1:0] retrig_r;
    logic                  steal_r;
    logic [3:0]            count_r;

    logic [NUM_VOICES-1:0] active_s;
    logic [NOTE_W-1:0]     note_s [NUM_VOICES];
    logic [RANK_W-1:0]     rank_s [NUM_VOICES];
    logic [NUM_VOICES-1:0] retrig_s;
    logic                  steal_s;
    logic [3:0]            count_s;

    logic                  off_hit_s;
    logic [RANK_W-1:0]     off_rank_s;
    logic                  on_hit_s;
    logic [RANK_W-1:0]     hit_rank_s;
    logic [NUM_VOICES-1:0] hit_sel_s;
    logic                  free_found_s;
    logic [NUM_VOICES-1:0] free_sel_s;
    logic [NUM_VOICES-1:0] old_sel_s;

    // Next-state: apply the release first, then allocate against the post-release state
    always_comb begin
        active_s     = active_r;
        note_s       = note_r;
        rank_s       = rank_r;
        retrig_s     = '0;
        steal_s      = 1'b0;
        off_hit_s    = 1'b0;
        off_rank_s   = '0;
        on_hit_s     = 1'b0;
        hit_rank_s   = '0;
        hit_sel_s    = '0;
        free_found_s = 1'b0;
        free_sel_s   = '0;
        old_sel_s    = '0;

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (key_off && !off_hit_s && active_s[i] && (note_s[i] == key_note)) begin
                off_hit_s   = 1'b1;
                off_rank_s  = rank_s[i];
                active_s[i] = 1'b0;
                rank_s[i]   = '0;
            end else begin
                active_s[i] = active_s[i];
            end
        end

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (off_hit_s && active_s[i] && (rank_s[i] > off_rank_s)) begin
                rank_s[i] = rank_s[i] - RANK_ONE;
            end else begin
                rank_s[i] = rank_s[i];
            end
        end

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!on_hit_s && active_s[i] && (note_s[i] == key_note)) begin
                on_hit_s     = 1'b1;
                hit_sel_s[i] = 1'b1;
                hit_rank_s   = rank_s[i];
            end else begin
                hit_sel_s[i] = hit_sel_s[i];
            end
            if (!free_found_s && !active_s[i]) begin
                free_found_s  = 1'b1;
                free_sel_s[i] = 1'b1;
            end else begin
                free_sel_s[i] = free_sel_s[i];
            end
            old_sel_s[i] = active_s[i] && (rank_s[i] == OLDEST_RANK);
        end

        if (key_on) begin
            if (on_hit_s) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (hit_sel_s[i]) begin
                        rank_s[i] = '0;
                    end else if (active_s[i] && (rank_s[i] < hit_rank_s)) begin
                        rank_s[i] = rank_s[i] + RANK_ONE;
                    end else begin
                        rank_s[i] = rank_s[i];
                    end
                end
                retrig_s = hit_sel_s;
            end else if (free_found_s) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (free_sel_s[i]) begin
                        active_s[i] = 1'b1;
                        note_s[i]   = key_note;
                        rank_s[i]   = '0;
                    end else if (active_s[i]) begin
                        rank_s[i] = rank_s[i] + RANK_ONE;
                    end else begin
                        rank_s[i] = rank_s[i];
                    end
                end
                retrig_s = free_sel_s;
            end else begin
                // Pool is full, so exactly one voice carries the oldest rank
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (old_sel_s[i]) begin
                        note_s[i] = key_note;
                        rank_s[i] = '0;
                    end else begin
                        rank_s[i] = rank_s[i] + RANK_ONE;
                    end
                end
                retrig_s = old_sel_s;
                steal_s  = 1'b1;
            end
        end else begin
            retrig_s = '0;
        end

        count_s = popcount(active_s);
    end

    // Voice state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= '0;
                rank_r[i] <= '0;
            end
            retrig_r <= '0;
            steal_r  <= 1'b0;
            count_r  <= 4'd0;
        end else begin
            active_r <= active_s;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= note_s[i];
                rank_r[i] <= rank_s[i];
            end
            retrig_r <= retrig_s;
            steal_r  <= steal_s;
            count_r  <= count_s;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : g_note
            assign voice_note[g*NOTE_W +: NOTE_W] = note_r[g];
        end
    endgenerate

    assign voice_enable = active_r;
    assign voice_retrig = retrig_r;
    assign steal        = steal_r;
    assign active_count = count_r;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: directed key events push hand-computed
// expected outputs; a negedge monitor pops and compares them when they fall due.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_on = 1'b0;
    logic        key_off = 1'b0;
    logic [4:0]  key_note = 5'd0;
    logic [11:0] voice_enable;
    logic [59:0] voice_note;
    logic [11:0] voice_retrig;
    logic        steal;
    logic [3:0]  active_count;

    voice_allocator #(.NUM_VOICES(12), .NOTE_W(5)) dut (
        .clk(clk), .rst(rst), .key_on(key_on), .key_off(key_off), .key_note(key_note),
        .voice_enable(voice_enable), .voice_note(voice_note), .voice_retrig(voice_retrig),
        .steal(steal), .active_count(active_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        logic [11:0] en;
        logic [59:0] notes;
        logic [11:0] rt;
        logic        st;
        logic [3:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         cyc = 0;
    int         step_id = 0;
    int         checks = 0;
    int         errors = 0;
    logic [4:0] exp_note [12];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [59:0] pack_notes();
        logic [59:0] p;
        p = 60'd0;
        for (int i = 0; i < 12; i++) p[i*5 +: 5] = exp_note[i];
        return p;
    endfunction

    // Monitor: compare every expectation that has fallen due this cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            checks++;
            if (voice_enable !== cur.en || voice_note !== cur.notes || voice_retrig !== cur.rt ||
                steal !== cur.st || active_count !== cur.cnt) begin
                errors++;
                $display("FAIL step%0d: got en=%h note=%h rt=%h steal=%b cnt=%0d, want en=%h note=%h rt=%h steal=%b cnt=%0d",
                         cur.id, voice_enable, voice_note, voice_retrig, steal, active_count,
                         cur.en, cur.notes, cur.rt, cur.st, cur.cnt);
            end
        end
    end

    task automatic step(input bit on, input bit off, input logic [4:0] n, input int setv,
                        input logic [11:0] en, input logic [11:0] rt, input bit st,
                        input logic [3:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        key_on   = on;
        key_off  = off;
        key_note = n;
        if (setv >= 0) exp_note[setv] = n;
        step_id++;
        e.due   = cyc + 1;
        e.id    = step_id;
        e.en    = en;
        e.notes = pack_notes();
        e.rt    = rt;
        e.st    = st;
        e.cnt   = cnt;
        sb.push_back(e);
    endtask

    // Asynchronous reset mid-cycle, discarding expectations it pre-empts
    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #2;
        rst     = 1'b1;
        key_on  = 1'b0;
        key_off = 1'b0;
        sb.delete();
        for (int i = 0; i < 12; i++) exp_note[i] = 5'd0;
        step_id++;
        e.due   = cyc;
        e.id    = step_id;
        e.en    = 12'h000;
        e.notes = 60'd0;
        e.rt    = 12'h000;
        e.st    = 1'b0;
        e.cnt   = 4'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] m;
        for (int i = 0; i < 12; i++) exp_note[i] = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step(1'b0, 1'b0, 5'd0,  -1, 12'h000, 12'h000, 1'b0, 4'd0);
        step(1'b1, 1'b0, 5'd3,   0, 12'h001, 12'h001, 1'b0, 4'd1);
        step(1'b1, 1'b0, 5'd7,   1, 12'h003, 12'h002, 1'b0, 4'd2);
        step(1'b1, 1'b0, 5'd9,   2, 12'h007, 12'h004, 1'b0, 4'd3);
        step(1'b0, 1'b1, 5'd7,  -1, 12'h005, 12'h000, 1'b0, 4'd2);
        step(1'b1, 1'b0, 5'd12,  1, 12'h007, 12'h002, 1'b0, 4'd3);
        step(1'b1, 1'b0, 5'd3,  -1, 12'h007, 12'h001, 1'b0, 4'd3);
        step(1'b1, 1'b0, 5'd3,  -1, 12'h007, 12'h001, 1'b0, 4'd3);
        step(1'b0, 1'b1, 5'd15, -1, 12'h007, 12'h000, 1'b0, 4'd3);
        step(1'b1, 1'b1, 5'd12,  1, 12'h007, 12'h002, 1'b0, 4'd3);
        step(1'b0, 1'b0, 5'd0,  -1, 12'h007, 12'h000, 1'b0, 4'd3);

        do_reset();
        step(1'b0, 1'b0, 5'd0, -1, 12'h000, 12'h000, 1'b0, 4'd0);
        for (int n = 0; n < 12; n++) begin
            m = (12'd1 << (n + 1)) - 12'd1;
            step(1'b1, 1'b0, 5'(n), n, m, 12'd1 << n, 1'b0, 4'(n + 1));
        end
        step(1'b1, 1'b0, 5'd20,  0, 12'hFFF, 12'h001, 1'b1, 4'd12);
        step(1'b1, 1'b0, 5'd21,  1, 12'hFFF, 12'h002, 1'b1, 4'd12);
        step(1'b0, 1'b1, 5'd20, -1, 12'hFFE, 12'h000, 1'b0, 4'd11);
        step(1'b1, 1'b0, 5'd22,  0, 12'hFFF, 12'h001, 1'b0, 4'd12);
        step(1'b1, 1'b0, 5'd23,  2, 12'hFFF, 12'h004, 1'b1, 4'd12);
        step(1'b1, 1'b0, 5'd23, -1, 12'hFFF, 12'h004, 1'b0, 4'd12);

        do_reset();
        step(1'b1, 1'b0, 5'd5,  0, 12'h001, 12'h001, 1'b0, 4'd1);
        step(1'b0, 1'b0, 5'd0, -1, 12'h001, 12'h000, 1'b0, 4'd1);

        @(posedge clk);
        #1;
        key_on  = 1'b0;
        key_off = 1'b0;
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
